// File: rtl/arm_pkg.sv
// arm_pkg: shared definitions for the ARM-style pipeline blocks.
//   REG_IDX_W - width of an architectural register index
//   NUM_REGS  - number of architectural registers (R0..R15)
//   reg_idx_t - register index type
//   PC_REG    - index of the program counter register
package arm_pkg;

   localparam int unsigned REG_IDX_W = 4;
   localparam int unsigned NUM_REGS  = 16;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   localparam reg_idx_t PC_REG = 4'd15;

endpackage

// File: rtl/sb_counter.sv
// sb_counter: saturating up/down pending-write counter for one register.
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset, clears the count
//   inc  in  add one (ignored when saturated)
//   dec  in  subtract one (ignored at zero)
//   cnt  out current count
//   sat  out count is at its maximum value
// inc and dec together leave the count unchanged.
module sb_counter #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             sat
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({inc, dec})
         2'b10:   if (cnt_q != CntMax) cnt_d = cnt_q + CNT_W'(1);
         2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign sat = (cnt_q == CntMax);

   // A retire with nothing pending means WB and ID disagree about in-flight writes.
   dec_at_zero_a: assert property (@(posedge clk) disable iff (rst)
      !(dec && !inc && (cnt_q == '0)));

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: register-write scoreboard producing the ID-stage stall.
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   src1, src2   in   source register indices of the instruction in ID
//   two_src      in   instruction in ID reads src2
//   id_wb_en     in   instruction in ID writes a register
//   id_mem_r_en  in   instruction in ID is a load
//   id_dest      in   destination register of the instruction in ID
//   freeze       in   pipeline frozen, ID does not advance
//   flush        in   instruction in ID is discarded at this edge
//   wb_en        in   WB stage writes the register file this cycle
//   wb_dest      in   register written by WB
//   hazard       out  stall request to IF/ID (combinational)
//   pending      out  bit r set while register r has writes in flight
//   sb_overflow  out  sticky: an issue hit a saturated counter
module hazard_scoreboard
   import arm_pkg::*;
#(
   parameter int unsigned NUM_REGS  = arm_pkg::NUM_REGS,
   parameter int unsigned CNT_W     = 2,
   parameter bit          FWD_EN    = 1'b0,
   parameter bit          WB_BYPASS = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  reg_idx_t            src1,
   input  reg_idx_t            src2,
   input  logic                two_src,
   input  logic                id_wb_en,
   input  logic                id_mem_r_en,
   input  reg_idx_t            id_dest,
   input  logic                freeze,
   input  logic                flush,
   input  logic                wb_en,
   input  reg_idx_t            wb_dest,
   output logic                hazard,
   output logic [NUM_REGS-1:0] pending,
   output logic                sb_overflow
);

   logic                issue;
   logic                retire;
   logic [NUM_REGS-1:0] inc_vec;
   logic [NUM_REGS-1:0] dec_vec;
   logic [NUM_REGS-1:0] sat_vec;
   logic [NUM_REGS-1:0] pend_vec;
   logic [NUM_REGS-1:0] busy;
   logic [CNT_W-1:0]    cnt [NUM_REGS];

   logic [NUM_REGS-1:0] ld_exe_q, ld_exe_d;
   logic                sb_overflow_q, sb_overflow_d;

   // hazard does not depend on issue, so there is no combinational loop here.
   always_comb begin
      if (FWD_EN) begin
         hazard = ld_exe_q[src1] | (two_src & ld_exe_q[src2]);
      end else begin
         hazard = busy[src1] | (two_src & busy[src2]);
      end
   end

   always_comb begin
      issue  = id_wb_en & ~hazard & ~freeze & ~flush;
      retire = wb_en;
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      assign inc_vec[r]  = issue & (id_dest == reg_idx_t'(r));
      assign dec_vec[r]  = retire & (wb_dest == reg_idx_t'(r));
      assign pend_vec[r] = (cnt[r] != '0);
      // The last in-flight write landing this cycle is visible to the ID read already.
      assign busy[r]     = pend_vec[r] &
                           ~(WB_BYPASS & dec_vec[r] & (cnt[r] == CNT_W'(1)));

      sb_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk (clk),
         .rst (rst),
         .inc (inc_vec[r]),
         .dec (dec_vec[r]),
         .cnt (cnt[r]),
         .sat (sat_vec[r])
      );
   end

   // inc_vec is onehot(id_dest) whenever issue is set.
   always_comb begin
      ld_exe_d = '0;
      if (FWD_EN) begin
         if (freeze) begin
            ld_exe_d = ld_exe_q;
         end else if (issue & id_mem_r_en) begin
            ld_exe_d = inc_vec;
         end
      end
   end

   always_comb begin
      sb_overflow_d = sb_overflow_q | (|(inc_vec & ~dec_vec & sat_vec));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ld_exe_q      <= '0;
         sb_overflow_q <= 1'b0;
      end else begin
         ld_exe_q      <= ld_exe_d;
         sb_overflow_q <= sb_overflow_d;
      end
   end

   assign pending     = pend_vec;
   assign sb_overflow = sb_overflow_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances share the stimulus
//   dut_b  : FWD_EN=0, WB_BYPASS=1
//   dut_nb : FWD_EN=0, WB_BYPASS=0
//   dut_f  : FWD_EN=1, WB_BYPASS=1
// Inputs change on the falling edge; results are sampled 1 ns later.
module tb_hazard_scoreboard;
   import arm_pkg::*;

   logic     clk = 1'b0;
   logic     rst;
   reg_idx_t src1, src2, id_dest, wb_dest;
   logic     two_src, id_wb_en, id_mem_r_en, freeze, flush, wb_en;

   logic        h0, h1, h2;
   logic [15:0] p0, p1, p2;
   logic        o0, o1, o2;

   typedef struct {
      string       nm;
      logic [15:0] v;
   } exp_t;

   exp_t sbq[$];
   int   n_tot = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.NUM_REGS(16), .CNT_W(2), .FWD_EN(1'b0), .WB_BYPASS(1'b1)) dut_b (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
      .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
      .freeze(freeze), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
      .hazard(h0), .pending(p0), .sb_overflow(o0)
   );

   hazard_scoreboard #(.NUM_REGS(16), .CNT_W(2), .FWD_EN(1'b0), .WB_BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
      .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
      .freeze(freeze), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
      .hazard(h1), .pending(p1), .sb_overflow(o1)
   );

   hazard_scoreboard #(.NUM_REGS(16), .CNT_W(2), .FWD_EN(1'b1), .WB_BYPASS(1'b1)) dut_f (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
      .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
      .freeze(freeze), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest),
      .hazard(h2), .pending(p2), .sb_overflow(o2)
   );

   task automatic idle();
      src1 = '0; src2 = '0; id_dest = '0; wb_dest = '0;
      two_src = 1'b0; id_wb_en = 1'b0; id_mem_r_en = 1'b0;
      freeze = 1'b0; flush = 1'b0; wb_en = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic push(input string nm, input logic [15:0] v);
      sbq.push_back('{nm: nm, v: v});
   endtask

   task automatic test_reset();
      exp_t e;
      @(negedge clk);
      idle();
      rst = 1'b1; src1 = 4'd3;
      push("rst_haz", 16'd0); push("rst_pend", 16'd0);
      #1;
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, h0} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h0}, e.v); end
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
      @(negedge clk);
      rst = 1'b0;
      push("rel_haz", 16'd0); push("rel_pend", 16'd0);
      #1;
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, h0} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h0}, e.v); end
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
      // Three writes in flight, then an asynchronous reset between clock edges.
      src1 = '0;
      id_wb_en = 1'b1; id_dest = 4'd1;
      @(negedge clk); id_dest = 4'd2;
      @(negedge clk); id_dest = 4'd3;
      @(negedge clk); id_wb_en = 1'b0;
      push("three_pend", 16'h000e);
      #1;
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
      push("async_rst_b", 16'd0); push("async_rst_nb", 16'd0); push("async_rst_f", 16'd0);
      rst = 1'b1;
      #1;
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
      e = sbq.pop_front(); n_tot++;
      if (p1 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p1, e.v); end
      e = sbq.pop_front(); n_tot++;
      if (p2 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p2, e.v); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_wb_bypass();
      exp_t e;
      do_reset();
      id_wb_en = 1'b1; id_dest = 4'd5;
      @(negedge clk);
      id_wb_en = 1'b0; src1 = 4'd5;
      for (int i = 0; i < 2; i++) begin
         push($sformatf("raw_b_%0d", i), 16'd1);
         push($sformatf("raw_nb_%0d", i), 16'd1);
         push($sformatf("raw_f_%0d", i), 16'd0);
         #1;
         e = sbq.pop_front(); n_tot++;
         if ({15'd0, h0} !== e.v) begin n_bad++;
            $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h0}, e.v); end
         e = sbq.pop_front(); n_tot++;
         if ({15'd0, h1} !== e.v) begin n_bad++;
            $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h1}, e.v); end
         e = sbq.pop_front(); n_tot++;
         if ({15'd0, h2} !== e.v) begin n_bad++;
            $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h2}, e.v); end
         @(negedge clk);
      end
      // Retire in flight: bypass drops now, no-bypass drops next cycle.
      wb_en = 1'b1; wb_dest = 4'd5;
      push("wb_same_b", 16'd0); push("wb_same_nb", 16'd1);
      #1;
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, h0} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h0}, e.v); end
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, h1} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h1}, e.v); end
      @(negedge clk);
      wb_en = 1'b0;
      push("wb_next_b", 16'd0); push("wb_next_nb", 16'd0); push("wb_next_pend", 16'd0);
      #1;
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, h0} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h0}, e.v); end
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, h1} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h1}, e.v); end
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      do_reset();
      id_wb_en = 1'b1; id_dest = 4'd2;
      @(negedge clk);
      @(negedge clk);
      id_wb_en = 1'b0;
      // Count is 2: a single retire must not clear the stall even with bypass.
      src1 = 4'd2; wb_en = 1'b1; wb_dest = 4'd2;
      push("b2b_haz_cnt2", 16'd1); push("b2b_pend2", 16'h0004);
      #1;
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, h0} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h0}, e.v); end
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
      @(negedge clk);
      push("b2b_after1", 16'h0004); push("b2b_haz_cnt1", 16'd0);
      #1;
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, h0} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h0}, e.v); end
      @(negedge clk);
      wb_en = 1'b0;
      push("b2b_after2", 16'h0000);
      #1;
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
   endtask

   task automatic test_flush_freeze();
      exp_t e;
      do_reset();
      id_wb_en = 1'b1; id_dest = 4'd7; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; id_wb_en = 1'b0;
      push("flush_nocount", 16'h0000);
      #1;
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
      freeze = 1'b1; id_wb_en = 1'b1;
      @(negedge clk);
      freeze = 1'b0;
      push("freeze_nocount", 16'h0000);
      #1;
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
      @(negedge clk);
      // Issue and retire of r7 in the same cycle: count stays at 1.
      wb_en = 1'b1; wb_dest = 4'd7;
      push("plain_issue", 16'h0080);
      #1;
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
      @(negedge clk);
      id_wb_en = 1'b0; wb_en = 1'b0;
      push("inc_dec_same", 16'h0080);
      #1;
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
      // Retires are accepted while frozen.
      freeze = 1'b1; wb_en = 1'b1;
      @(negedge clk);
      freeze = 1'b0; wb_en = 1'b0;
      push("retire_frozen", 16'h0000);
      #1;
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
   endtask

   task automatic test_load_use();
      exp_t e;
      do_reset();
      id_wb_en = 1'b1; id_mem_r_en = 1'b1; id_dest = 4'd4;
      @(negedge clk);
      id_wb_en = 1'b0; id_mem_r_en = 1'b0; src2 = 4'd4; two_src = 1'b1;
      push("lu_cyc0", 16'd1); push("lu_nofwd", 16'd1);
      #1;
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, h2} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h2}, e.v); end
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, h0} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h0}, e.v); end
      @(negedge clk);
      push("lu_cyc1", 16'd0);
      #1;
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, h2} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h2}, e.v); end
      // Same load-use pair with the pipeline frozen for three cycles.
      do_reset();
      id_wb_en = 1'b1; id_mem_r_en = 1'b1; id_dest = 4'd4;
      @(negedge clk);
      id_wb_en = 1'b0; id_mem_r_en = 1'b0; src2 = 4'd4; two_src = 1'b1;
      for (int i = 0; i < 5; i++) begin
         freeze = (i < 3);
         push($sformatf("lu_frz_%0d", i), (i < 4) ? 16'd1 : 16'd0);
         #1;
         e = sbq.pop_front(); n_tot++;
         if ({15'd0, h2} !== e.v) begin n_bad++;
            $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h2}, e.v); end
         @(negedge clk);
      end
      freeze = 1'b0;
      // A non-load writer of r4 needs no stall with forwarding.
      do_reset();
      id_wb_en = 1'b1; id_dest = 4'd4;
      @(negedge clk);
      id_wb_en = 1'b0; src2 = 4'd4; two_src = 1'b1;
      push("nonload_f", 16'd0); push("nonload_b", 16'd1);
      #1;
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, h2} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h2}, e.v); end
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, h0} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, h0}, e.v); end
   endtask

   task automatic test_saturate();
      exp_t e;
      do_reset();
      id_wb_en = 1'b1; id_dest = 4'd9;
      repeat (3) @(negedge clk);
      push("sat3_pend", 16'h0200); push("sat3_ovf", 16'd0);
      #1;
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, o0} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, o0}, e.v); end
      @(negedge clk);
      id_wb_en = 1'b0;
      repeat (2) @(negedge clk);
      push("sat4_ovf_b", 16'd1); push("sat4_ovf_nb", 16'd1); push("sat4_ovf_f", 16'd1);
      #1;
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, o0} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, o0}, e.v); end
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, o1} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, o1}, e.v); end
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, o2} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, o2}, e.v); end
      // Saturated at 3: exactly three retires drain it.
      wb_en = 1'b1; wb_dest = 4'd9;
      repeat (2) @(negedge clk);
      push("sat_drain2", 16'h0200);
      #1;
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
      @(negedge clk);
      wb_en = 1'b0;
      push("sat_drain3", 16'h0000); push("sat_ovf_sticky", 16'd1);
      #1;
      e = sbq.pop_front(); n_tot++;
      if (p0 !== e.v) begin n_bad++; $display("FAIL %s: got %h exp %h", e.nm, p0, e.v); end
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, o0} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, o0}, e.v); end
      do_reset();
      push("ovf_cleared", 16'd0);
      #1;
      e = sbq.pop_front(); n_tot++;
      if ({15'd0, o0} !== e.v) begin n_bad++;
         $display("FAIL %s: got %h exp %h", e.nm, {15'd0, o0}, e.v); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      rst = 1'b1;
      test_reset();
      test_wb_bypass();
      test_back_to_back();
      test_flush_freeze();
      test_load_use();
      test_saturate();
      if (sbq.size() != 0) begin
         n_tot++; n_bad++;
         $display("FAIL sb_leftover: got %0d exp 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
